// File: rtl/apu_audio_pkg.sv
// apu_audio_pkg: register offsets, CSR bit positions and duty helpers for apu_audio_out
package apu_audio_pkg;
  localparam logic [1:0] REG_CSR = 2'd0;
  localparam logic [1:0] REG_DIV = 2'd1;
  localparam logic [1:0] REG_FIFO = 2'd2;
  localparam int CSR_EN = 0;
  localparam int CSR_FLUSH = 1;
  localparam int CSR_IRQ_EN = 2;
  localparam int CSR_THRESH = 8;
  localparam int CSR_LEVEL = 16;
  localparam int CSR_UNDERFLOW = 24;
  localparam int CSR_OVERFLOW = 25;
  localparam int CSR_FULL = 26;
  localparam int CSR_EMPTY = 27;
  localparam int CSR_FIELD_W = 4;
  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/apu_audio_fifo.sv
// apu_audio_fifo: flop FIFO with push/pop/flush and occupancy flags
module apu_audio_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop, do_push;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the slot the same cycle, so a push while full still lands
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/apu_audio_out.sv
// apu_audio_out: AHB-Lite sample FIFO, sample-rate scheduler and stereo PWM outputs
module apu_audio_out import apu_audio_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int W_PWM = 8,
  parameter int W_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ahbls_haddr,
  input  logic [1:0]  ahbls_htrans,
  input  logic        ahbls_hwrite,
  input  logic [2:0]  ahbls_hsize,
  input  logic        ahbls_hready,
  input  logic [31:0] ahbls_hwdata,
  output logic        ahbls_hready_resp,
  output logic        ahbls_hresp,
  output logic [31:0] ahbls_hrdata,
  output logic        irq,
  output logic        audio_l,
  output logic        audio_r
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [W_PWM-1:0] MID = W_PWM'(midscale(W_PWM));
  logic ap_valid, ap_write;
  logic [1:0] ap_addr;
  logic en, irq_en, uf, of;
  logic [CSR_FIELD_W-1:0] thresh;
  logic [W_DIV-1:0] div, divctr;
  logic [W_PWM-1:0] ctr, duty_l, duty_r;
  logic [31:0] sample, csr_rd;
  logic [LW-1:0] level;
  logic full, empty, wr_csr, wr_div, push, flush, wrap, tick, pop, unused;
  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp = 1'b0;
  assign unused = ^{ahbls_haddr[15:4], ahbls_haddr[1:0], ahbls_htrans[0], ahbls_hsize, sample};
  assign wr_csr = ap_valid && ap_write && ap_addr == REG_CSR;
  assign wr_div = ap_valid && ap_write && ap_addr == REG_DIV;
  assign push = ap_valid && ap_write && ap_addr == REG_FIFO;
  assign flush = wr_csr && ahbls_hwdata[CSR_FLUSH];
  assign wrap = en && ctr == '1;
  assign tick = wrap && divctr == div;
  assign pop = tick && !empty;
  assign irq = irq_en && 32'(level) <= 32'(thresh);
  assign audio_l = en && ctr < duty_l;
  assign audio_r = en && ctr < duty_r;
  apu_audio_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .wdata(ahbls_hwdata), .rdata(sample), .level(level), .full(full), .empty(empty)
  );
  always_comb begin
    csr_rd = '0;
    csr_rd[CSR_EN] = en;
    csr_rd[CSR_IRQ_EN] = irq_en;
    csr_rd[CSR_THRESH +: CSR_FIELD_W] = thresh;
    csr_rd[CSR_LEVEL +: CSR_FIELD_W] = CSR_FIELD_W'(level);
    csr_rd[CSR_UNDERFLOW] = uf;
    csr_rd[CSR_OVERFLOW] = of;
    csr_rd[CSR_FULL] = full;
    csr_rd[CSR_EMPTY] = empty;
    ahbls_hrdata = !ap_valid || ap_write ? '0 :
                   ap_addr == REG_CSR ? csr_rd :
                   ap_addr == REG_DIV ? 32'(div) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_addr <= '0;
    end else if (ahbls_hready) begin
      ap_valid <= ahbls_htrans[1];
      ap_write <= ahbls_hwrite;
      ap_addr <= ahbls_haddr[3:2];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
      div <= '0;
      uf <= 1'b0;
      of <= 1'b0;
    end else begin
      if (wr_csr) begin
        en <= ahbls_hwdata[CSR_EN];
        irq_en <= ahbls_hwdata[CSR_IRQ_EN];
        thresh <= ahbls_hwdata[CSR_THRESH +: CSR_FIELD_W];
      end
      if (wr_div) div <= ahbls_hwdata[W_DIV-1:0];
      // a hardware event in the same cycle as the clear wins
      uf <= (tick && empty) || (uf && !(wr_csr && ahbls_hwdata[CSR_UNDERFLOW]));
      of <= (push && full && !pop && !flush) || (of && !(wr_csr && ahbls_hwdata[CSR_OVERFLOW]));
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctr <= '0;
      divctr <= '0;
      duty_l <= MID;
      duty_r <= MID;
    end else if (!en) begin
      ctr <= '0;
      divctr <= '0;
      duty_l <= MID;
      duty_r <= MID;
    end else begin
      ctr <= ctr + 1'b1;
      if (wrap) divctr <= tick ? '0 : divctr + 1'b1;
      if (pop) begin
        duty_l <= sample[15 -: W_PWM] ^ MID;
        duty_r <= sample[31 -: W_PWM] ^ MID;
      end
    end
endmodule

// File: tb/tb_apu_audio_out.sv
// tb_apu_audio_out: randomized and directed checks of apu_audio_out against a sample-queue model
module tb_apu_audio_out;
  localparam int DEPTH = 8;
  localparam int PER = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] haddr = '0;
  logic [1:0] htrans = '0;
  logic hwrite = 1'b0;
  logic [2:0] hsize = 3'd2;
  logic hready = 1'b1;
  logic [31:0] hwdata = '0;
  logic hready_resp, hresp, irq, audio_l, audio_r;
  logic [31:0] hrdata;
  int n_vec = 0;
  int n_err = 0;
  bit m_en, m_irq_en, m_uf, m_of;
  int m_thresh, m_div, m_dl, m_dr;
  longint m_k;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  apu_audio_out dut (
    .clk(clk), .rst_n(rst_n), .ahbls_haddr(haddr), .ahbls_htrans(htrans),
    .ahbls_hwrite(hwrite), .ahbls_hsize(hsize), .ahbls_hready(hready),
    .ahbls_hwdata(hwdata), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
    .ahbls_hrdata(hrdata), .irq(irq), .audio_l(audio_l), .audio_r(audio_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_irq_en = 0; m_uf = 0; m_of = 0;
    m_thresh = 0; m_div = 0; m_dl = PER / 2; m_dr = PER / 2; m_k = 0;
    m_q.delete();
  endtask

  // offset binary: signed top byte plus half scale
  function automatic int to_duty(input logic [15:0] s);
    return int'($signed(s[15:8])) + PER / 2;
  endfunction

  function automatic logic [31:0] exp_csr();
    int sz;
    sz = m_q.size();
    return 32'(m_en) | 32'(m_irq_en) << 2 | 32'(m_thresh) << 8 | 32'(sz) << 16 |
           32'(m_uf) << 24 | 32'(m_of) << 25 | 32'(sz == DEPTH) << 26 | 32'(sz == 0) << 27;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    return a == 2'd0 ? exp_csr() : a == 2'd1 ? 32'(m_div) : 32'd0;
  endfunction

  function automatic logic [2:0] exp_pins();
    int p;
    p = int'(m_k % PER);
    return {m_en && p < m_dl, m_en && p < m_dr, m_irq_en && m_q.size() <= m_thresh};
  endfunction

  // advance one clock; ev marks that this cycle was a data phase of (wr, a, d)
  task automatic step(input bit ev, input bit wr, input logic [1:0] a, input logic [31:0] d);
    bit tick, popd, uf_set, of_set, flush;
    int sz;
    logic [31:0] s;
    @(posedge clk);
    #1;
    tick = m_en && ((m_k + 1) % ((m_div + 1) * PER) == 0);
    sz = m_q.size();
    popd = tick && sz > 0;
    uf_set = tick && sz == 0;
    of_set = 0;
    if (popd) begin
      s = m_q.pop_front();
      m_dl = to_duty(s[15:0]);
      m_dr = to_duty(s[31:16]);
    end
    flush = ev && wr && a == 2'd0 && d[1];
    if (flush) m_q.delete();
    else if (ev && wr && a == 2'd2) begin
      if (sz == DEPTH && !popd) of_set = 1;
      else m_q.push_back(d);
    end
    if (m_en) m_k++;
    if (ev && wr && a == 2'd0) begin
      if (d[24]) m_uf = 0;
      if (d[25]) m_of = 0;
      m_en = d[0];
      m_irq_en = d[2];
      m_thresh = int'(d[11:8]);
    end
    if (uf_set) m_uf = 1;
    if (of_set) m_of = 1;
    if (ev && wr && a == 2'd1) m_div = int'(d[7:0]);
    if (!m_en) begin
      m_k = 0;
      m_dl = PER / 2;
      m_dr = PER / 2;
    end
    check("pins_lri", 32'({audio_l, audio_r, irq}), 32'(exp_pins()));
  endtask

  task automatic bus(input bit wr, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
    haddr = 16'($urandom);
    haddr[3:2] = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize = 3'($urandom_range(0, 2));
    step(0, 0, 2'd0, 32'd0);
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = wr ? d : $urandom;
    rd = hrdata;
    check(wr ? "hrdata_wr" : "hrdata_rd", hrdata, wr ? 32'd0 : exp_read(a));
    step(1, wr, a, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] x;
    bus(1, a, d, x);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus(0, a, 32'd0, v);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 2'd0, 32'd0);
  endtask

  task automatic hard_reset();
    htrans = 2'b00;
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_pins", 32'({audio_l, audio_r, irq}), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 2'd0, 32'd0);
  endtask

  task automatic random_ops(input int n);
    int op;
    logic [31:0] d, v;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      d = $urandom;
      if (i == n / 2) hard_reset();
      if (op < 3) wr(2'd2, d);
      else if (op < 5) rd(2'($urandom_range(0, 3)), v);
      else if (op < 7) begin
        d[0] = $urandom_range(0, 3) != 0;
        d[1] = $urandom_range(0, 7) == 0;
        wr(2'd0, d);
      end else if (op == 7) begin
        if (!m_en) wr(2'd1, 32'($urandom_range(0, 2)));
        else wr(2'd3, d);
      end else idle($urandom_range(0, 150));
    end
  endtask

  initial begin
    logic [31:0] v;
    int cl, cr, t;
    hard_reset();
    rd(2'd0, v);
    check("rst_csr", v, 32'h0800_0000);
    rd(2'd1, v);
    check("rst_div", v, 32'd0);

    wr(2'd1, 32'd0);
    wr(2'd2, 32'h4000_C000);
    wr(2'd0, 32'd1);
    while (m_k != PER) step(0, 0, 2'd0, 32'd0);
    cl = 0; cr = 0;
    for (int i = 0; i < PER; i++) begin
      cl += int'(audio_l);
      cr += int'(audio_r);
      step(0, 0, 2'd0, 32'd0);
    end
    check("duty_l_high", 32'(cl), 32'd64);
    check("duty_r_high", 32'(cr), 32'd192);

    hard_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h0000_0204);
    for (int i = 0; i < 4; i++) wr(2'd2, $urandom);
    rd(2'd0, v);
    check("thr_level4", 32'(v[19:16]), 32'd4);
    check("thr_irq_low", 32'(irq), 32'd0);
    wr(2'd0, 32'h0000_0205);
    t = 0;
    while (!irq && t < 1400) begin
      step(0, 0, 2'd0, 32'd0);
      t++;
    end
    check("thr_rise_k", 32'(m_k), 32'd1024);

    hard_reset();
    wr(2'd2, 32'h7FFF_8000);
    wr(2'd0, 32'd1);
    while (m_k != 2 * PER + 100) step(0, 0, 2'd0, 32'd0);
    check("uf_keep_duty", 32'({audio_l, audio_r}), 32'd1);
    rd(2'd0, v);
    check("uf_set", 32'(v[24]), 32'd1);
    wr(2'd0, 32'h0100_0001);
    rd(2'd0, v);
    check("uf_cleared", 32'(v[24]), 32'd0);

    hard_reset();
    for (int i = 0; i < 9; i++) wr(2'd2, 32'h4000_C000);
    rd(2'd0, v);
    check("ovf_level8", 32'(v[19:16]), 32'd8);
    check("ovf_set", 32'(v[25]), 32'd1);
    wr(2'd0, 32'h0200_0001);
    while ((m_k + 2) % PER != 0) step(0, 0, 2'd0, 32'd0);
    wr(2'd2, 32'h4000_C000);
    rd(2'd0, v);
    check("tickpush_level", 32'(v[19:16]), 32'd8);
    check("tickpush_no_ovf", 32'(v[25]), 32'd0);

    wr(2'd0, 32'h0000_0003);
    rd(2'd0, v);
    check("flush_level0", 32'(v[19:16]), 32'd0);
    while (m_k % PER != 10) step(0, 0, 2'd0, 32'd0);
    check("pre_dis_pins", 32'({audio_l, audio_r}), 32'd3);
    wr(2'd0, 32'd0);
    check("dis_pins", 32'({audio_l, audio_r}), 32'd0);
    wr(2'd0, 32'd1);
    cl = 0;
    for (int i = 0; i < PER; i++) begin
      cl += int'(audio_l);
      step(0, 0, 2'd0, 32'd0);
    end
    check("reen_mid", 32'(cl), 32'(PER / 2));

    hard_reset();
    random_ops(400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apu_audio_out.md
# apu_audio_out

Audio output controller for the APU, mapped as a 4 kB AHB-Lite peripheral in the upper 32k of the APU address space, alongside the IPC registers. The APU CPU pushes stereo 16-bit samples into a small FIFO. A sample-rate scheduler pops one sample per programmed number of PWM periods and loads it into two PWM generators that drive the `audio_l`/`audio_r` pads. An interrupt requests a refill when the FIFO level falls to a programmed threshold.

## Interface
- `FIFO_DEPTH`, default 8: sample FIFO entries. Power of two, ≥2.
- `W_PWM`, default 8: PWM resolution in bits. PWM period is 2^W_PWM clk cycles.
- `W_DIV`, default 8: width of the sample divider field.
- `clk` in 1: system clock. Reset is `rst_n`, asynchronous, active-low; clock is `clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `ahbls_haddr` in 16: AHB address. Only [3:2] are decoded.
- `ahbls_htrans` in 2, `ahbls_hwrite` in 1, `ahbls_hsize` in 3, `ahbls_hready` in 1: AHB address-phase signals.
- `ahbls_hwdata` in 32: write data.
- `ahbls_hready_resp` out 1: tied to 1. Zero wait states.
- `ahbls_hresp` out 1: tied to 0.
- `ahbls_hrdata` out 32: read data, driven during the data phase.
- `irq` out 1: level-sensitive refill request.
- `audio_l`, `audio_r` out 1: PWM outputs.

## Operation
- **Register map (word offsets):**
  - 0x0 CSR: EN[0]; FLUSH[1] (write-1, self-clearing, reads 0); IRQ_EN[2]; THRESH[11:8]; LEVEL[19:16] (read-only); UNDERFLOW[24] and OVERFLOW[25] (sticky, write-1-to-clear); FULL[26] and EMPTY[27] (read-only).
  - 0x4 DIV: [W_DIV-1:0].
  - 0x8 FIFO: write-only push of {R[31:16], L[15:0]}. Reads return 0.
  - 0xC: reads 0, writes ignored.
- **Transfer qualification:** the address phase is captured when `hready && htrans[1]`. Writes take effect on the data-phase cycle using `hwdata`. Byte and halfword writes are treated as full-word writes.
- **Sample format:** samples are two's complement. Duty = top W_PWM bits of the sample with the MSB inverted, giving offset binary. 0x0000 maps to midscale.
- **PWM:**
  - A W_PWM-bit counter `ctr` runs while EN=1.
  - Each output is high while `ctr < duty`.
  - Duty registers load only at period wrap (`ctr` = all-ones → 0), so there are never mid-period glitches.
- **Scheduler:**
  - `divctr` increments at each wrap.
  - A sample tick fires at the wrap where `divctr == DIV`; `divctr` then clears to 0.
  - On a tick with the FIFO non-empty: pop and load both duty registers.
  - On a tick with the FIFO empty: set UNDERFLOW and keep the previous duty.
- **FIFO writes and flush:**
  - A push while full is dropped and sets OVERFLOW.
  - A push and pop in the same cycle while full: both occur, LEVEL is unchanged.
  - A push and tick in the same cycle while empty: UNDERFLOW is set and the push is accepted.
  - FLUSH empties the FIFO. A push in the same cycle as FLUSH is dropped, and OVERFLOW is not set.
- **EN=0:**
  - `ctr`, `divctr` and both outputs are held at 0.
  - Duty registers are preset to midscale (2^(W_PWM-1)).
  - The FIFO keeps its contents and accepts pushes, so software can pre-fill before enabling.
- `irq` = IRQ_EN && (LEVEL ≤ THRESH). No sticky pending state is kept.

## Timing
- Reset values:
  - `audio_l`, `audio_r`, `irq` = 0; `hrdata` = 0.
  - CSR = 0, so LEVEL = 0 and EMPTY reads 1; DIV = 0.
  - FIFO empty; `ctr` = `divctr` = 0; duty = midscale.
- A CSR or DIV write is visible to the next transfer and to the datapath in the cycle after the data phase.
- A FIFO push updates LEVEL/`irq` in the cycle after the data phase.
- A pop updates LEVEL/`irq` in the cycle after the wrap.
- Pop to output: the new duty drives the pins from the first cycle of the next PWM period, i.e. the cycle in which `ctr` = 0.
- The first tick after EN 0→1 fires at the end of PWM period DIV+1. Sample period = (DIV+1)·2^W_PWM cycles.
- EN 1→0 mid-period: outputs go to 0 on the next cycle and the in-flight period is abandoned.
- Asynchronous reset mid-operation returns all state to the reset values above. No partial flush is performed.

## Structure
- Package `apu_audio_pkg`:
  - register offsets;
  - CSR bit positions: EN, FLUSH, IRQ_EN, THRESH, LEVEL, UNDERFLOW, OVERFLOW, FULL, EMPTY;
  - the midscale constant function.
- Sub-module `apu_audio_fifo`: synchronous flop FIFO, 32 bits wide, FIFO_DEPTH entries. Provides push/pop/flush with level, full and empty outputs.
- The top level contains the AHB register block, scheduler, and two PWM comparators.

## Test plan
- **Reset read-back:** after reset, read CSR → 0x0800_0000 (EMPTY=1) and DIV → 0. `audio_*` = 0 and `irq` = 0 throughout.
- **Duty check:** DIV=0; push 0x4000_C000; set EN=1. From the second PWM period on, `audio_l` is high for exactly 64 cycles and `audio_r` for exactly 192 cycles per 256.
- **Threshold IRQ:** THRESH=2, IRQ_EN=1, DIV=1; push 4 samples, then set EN=1.
  - `irq` is 0 with LEVEL=4.
  - `irq` rises 1 cycle after the 2nd pop (LEVEL=2), which occurs at cycle ~1024.
- **Underflow:** push 1 sample with EN=1 and DIV=0. After the 2nd tick, UNDERFLOW=1 and the outputs keep the last duty. A write of 1<<24 clears UNDERFLOW.
- **Overflow and simultaneous events:** push 9 samples with EN=0 → LEVEL=8 and OVERFLOW=1. Then push in the exact cycle of a tick while full → LEVEL stays 8 and OVERFLOW is not newly set.
- **Flush and disable:** FLUSH while full → LEVEL=0 next cycle. Clearing EN mid-period drives the outputs to 0 within 1 cycle; re-enabling restarts at midscale.
